// File: rtl/alu_issue_ctrl_pkg.sv
// Shared ALU funct3 codes, issue-controller FSM state codes and response flag bundle.
// Imported by the issue controller, its arbiter and the bench.
package alu_issue_ctrl_pkg;

    localparam logic [2:0] ALU_ADDSUB = 3'd0;
    localparam logic [2:0] ALU_SLL    = 3'd1;
    localparam logic [2:0] ALU_SLT    = 3'd2;
    localparam logic [2:0] ALU_SLTU   = 3'd3;
    localparam logic [2:0] ALU_XOR    = 3'd4;
    localparam logic [2:0] ALU_SRLSRA = 3'd5;
    localparam logic [2:0] ALU_OR     = 3'd6;
    localparam logic [2:0] ALU_AND    = 3'd7;

    typedef enum logic [1:0] {
        ALUQ_IDLE  = 2'd0,
        ALUQ_ISSUE = 2'd1,
        ALUQ_WAIT  = 2'd2,
        ALUQ_RESP  = 2'd3
    } aluq_state_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic err;
    } rsp_flags_t;

endpackage

// File: rtl/alu_issue_ctrl_rr_arb2.sv
// Two-input round-robin arbiter, purely combinational (0 cycles); a lone requester always wins,
// on contention i_ptr names the favoured port. No backpressure of its own.
module alu_issue_ctrl_rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt
);

    always_comb begin
        o_gnt = i_req;
        if (&i_req) begin
            o_gnt = i_ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares one multi-cycle ALU between two requesters: accept @T, alu_start @T+1, result @T+3 at best.
// One op in flight; requesters stall (ready low) outside IDLE, start waits on alu_busy, RESP holds until rspN_ready.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [6:0]      req0_fun7,
    input  logic [2:0]      req0_fun3,
    input  logic [XLEN-1:0] req0_rs1,
    input  logic [XLEN-1:0] req0_rs2,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [6:0]      req1_fun7,
    input  logic [2:0]      req1_fun3,
    input  logic [XLEN-1:0] req1_rs1,
    input  logic [XLEN-1:0] req1_rs2,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp_res,
    output logic            rsp_zero,
    output logic            rsp_neg,
    output logic            rsp_err,
    output logic            alu_start,
    output logic [6:0]      alu_fun7,
    output logic [2:0]      alu_fun3,
    output logic [XLEN-1:0] alu_rs1,
    output logic [XLEN-1:0] alu_rs2,
    input  logic [XLEN-1:0] alu_res,
    input  logic            alu_done,
    input  logic            alu_busy
);

    localparam int            CW      = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT - 1);

    aluq_state_t     r_state;
    aluq_state_t     w_state_nxt;
    logic            r_ptr;
    logic            r_owner;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_res;
    rsp_flags_t      r_flags;
    logic [1:0]      w_gnt;
    logic            w_accept;
    logic            w_rsp_hs;
    logic            w_timeout;

    alu_issue_ctrl_rr_arb2 u_arb (
        .i_req (({req1_valid, req0_valid})),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt)
    );

    assign w_accept  = (r_state == ALUQ_IDLE) && (req0_valid || req1_valid);
    assign w_rsp_hs  = (r_state == ALUQ_RESP) && (r_owner ? rsp1_ready : rsp0_ready);
    assign w_timeout = (r_cnt == CNT_LIM);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ALUQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ALUQ_IDLE:  if (w_accept)              w_state_nxt = ALUQ_ISSUE;
            ALUQ_ISSUE: if (!alu_busy)             w_state_nxt = ALUQ_WAIT;
            ALUQ_WAIT:  if (alu_done || w_timeout) w_state_nxt = ALUQ_RESP;
            ALUQ_RESP:  if (w_rsp_hs)              w_state_nxt = ALUQ_IDLE;
            default:                               w_state_nxt = ALUQ_IDLE;
        endcase
    end

    always_comb begin
        req0_ready = (r_state == ALUQ_IDLE) && w_gnt[0];
        req1_ready = (r_state == ALUQ_IDLE) && w_gnt[1];
        alu_start  = (r_state == ALUQ_ISSUE) && !alu_busy;
        rsp0_valid = (r_state == ALUQ_RESP) && !r_owner;
        rsp1_valid = (r_state == ALUQ_RESP) && r_owner;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr    <= 1'b0;
            r_owner  <= 1'b0;
            r_cnt    <= '0;
            alu_fun7 <= '0;
            alu_fun3 <= '0;
            alu_rs1  <= '0;
            alu_rs2  <= '0;
            r_res    <= '0;
            r_flags  <= '0;
        end else begin
            if (w_accept) begin
                r_owner  <= w_gnt[1];
                alu_fun7 <= w_gnt[1] ? req1_fun7 : req0_fun7;
                alu_fun3 <= w_gnt[1] ? req1_fun3 : req0_fun3;
                alu_rs1  <= w_gnt[1] ? req1_rs1  : req0_rs1;
                alu_rs2  <= w_gnt[1] ? req1_rs2  : req0_rs2;
            end

            if (alu_start) begin
                r_cnt <= '0;
            end else if (r_state == ALUQ_WAIT) begin
                r_cnt <= r_cnt + CW'(1);
            end

            // done is checked before the limit so a completion on the last WAIT cycle is not reported as a timeout
            if (r_state == ALUQ_WAIT) begin
                if (alu_done) begin
                    r_res        <= alu_res;
                    r_flags.zero <= (alu_res == '0);
                    r_flags.neg  <= alu_res[XLEN-1];
                    r_flags.err  <= 1'b0;
                end else if (w_timeout) begin
                    r_res        <= '0;
                    r_flags.zero <= 1'b1;
                    r_flags.neg  <= 1'b0;
                    r_flags.err  <= 1'b1;
                end
            end

            if (w_rsp_hs) begin
                r_ptr <= ~r_owner;
            end
        end
    end

    assign rsp_res  = r_res;
    assign rsp_zero = r_flags.zero;
    assign rsp_neg  = r_flags.neg;
    assign rsp_err  = r_flags.err;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: behavioural ALU with programmable done delay and busy,
// per-port expected-response queues drained by an independent monitor.
module tb_alu_issue_ctrl;
    import alu_issue_ctrl_pkg::*;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            req0_valid, req0_ready, req1_valid, req1_ready;
    logic [6:0]      req0_fun7, req1_fun7;
    logic [2:0]      req0_fun3, req1_fun3;
    logic [XLEN-1:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
    logic            rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [XLEN-1:0] rsp_res;
    logic            rsp_zero, rsp_neg, rsp_err;
    logic            alu_start;
    logic [6:0]      alu_fun7;
    logic [2:0]      alu_fun3;
    logic [XLEN-1:0] alu_rs1, alu_rs2, alu_res;
    logic            alu_done, alu_busy;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fun7(req0_fun7),
        .req0_fun3(req0_fun3), .req0_rs1(req0_rs1), .req0_rs2(req0_rs2),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fun7(req1_fun7),
        .req1_fun3(req1_fun3), .req1_rs1(req1_rs1), .req1_rs2(req1_rs2),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_res(rsp_res), .rsp_zero(rsp_zero), .rsp_neg(rsp_neg), .rsp_err(rsp_err),
        .alu_start(alu_start), .alu_fun7(alu_fun7), .alu_fun3(alu_fun3),
        .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_res(alu_res),
        .alu_done(alu_done), .alu_busy(alu_busy)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [XLEN-1:0] res;
        logic            zero;
        logic            neg;
        logic            err;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    function automatic exp_t mk(input logic [XLEN-1:0] res, input logic z, input logic n, input logic e);
        exp_t x;
        x.res  = res;
        x.zero = z;
        x.neg  = n;
        x.err  = e;
        return x;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural ALU: done is asserted done_delay cycles after start (0 = never); result is junk otherwise.
    int unsigned     done_delay = 1;
    int unsigned     left       = 0;
    logic [XLEN-1:0] model_res  = '0;

    function automatic logic [XLEN-1:0] alu_fn(input logic [6:0] f7, input logic [2:0] f3,
                                               input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        case (f3)
            ALU_ADDSUB: return f7[5] ? a - b : a + b;
            ALU_XOR:    return a ^ b;
            ALU_OR:     return a | b;
            ALU_AND:    return a & b;
            default:    return '0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (alu_start) begin
            left      <= done_delay;
            model_res <= alu_fn(alu_fun7, alu_fun3, alu_rs1, alu_rs2);
        end else if (left != 0) begin
            left <= left - 1;
        end
    end

    assign alu_done = (left == 1);
    assign alu_res  = alu_done ? model_res : 32'hDEAD_BEEF;

    // Response monitor: pops the owning port's queue on every completed response handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) begin
                chk("rsp_valid_onehot", rsp0_valid & rsp1_valid, 0);
            end
            if (rsp0_valid && rsp0_ready) begin
                if (q0.size() == 0) begin
                    chk("rsp0_unexpected", 1, 0);
                end else begin
                    e = q0.pop_front();
                    chk("rsp0_res_zero_neg_err", {rsp_res, rsp_zero, rsp_neg, rsp_err}, e);
                end
            end
            if (rsp1_valid && rsp1_ready) begin
                if (q1.size() == 0) begin
                    chk("rsp1_unexpected", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chk("rsp1_res_zero_neg_err", {rsp_res, rsp_zero, rsp_neg, rsp_err}, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic idle_reqs();
        req0_valid = 1'b0; req0_fun7 = '0; req0_fun3 = '0; req0_rs1 = '0; req0_rs2 = '0;
        req1_valid = 1'b0; req1_fun7 = '0; req1_fun3 = '0; req1_rs1 = '0; req1_rs2 = '0;
    endtask

    task automatic drive(input int port, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        if (port == 0) begin
            req0_valid = 1'b1; req0_fun7 = f7; req0_fun3 = f3; req0_rs1 = a; req0_rs2 = b;
        end else begin
            req1_valid = 1'b1; req1_fun7 = f7; req1_fun3 = f3; req1_rs1 = a; req1_rs2 = b;
        end
    endtask

    // Single-requester issue; returns at #1 after the accept edge (the ISSUE cycle).
    task automatic issue(input string name, input int port, input logic [6:0] f7, input logic [2:0] f3,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input exp_t e);
        drive(port, f7, f3, a, b);
        if (port == 0) q0.push_back(e);
        else           q1.push_back(e);
        @(negedge clk);
        chk({name, "_ready_same_cycle"}, (port == 0) ? req0_ready : req1_ready, 1);
        @(posedge clk); #1;
        idle_reqs();
    endtask

    // Waits for all expected responses; returns at #1 into the IDLE cycle that follows.
    task automatic wait_drain(input string name);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
            @(negedge clk); #1;
            n++;
        end
        chk({name, "_drained"}, q0.size() + q1.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    // Counts negedges from the ISSUE cycle (n=1) to the first cycle showing a response.
    task automatic rsp_latency(input string name, input int exp_n);
        int n = 1;
        @(negedge clk);
        while (!(rsp0_valid || rsp1_valid) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_cycles_to_rsp"}, n, exp_n);
    endtask

    initial begin
        int   bad;
        int   n;
        logic g_exp [4];

        reset = 1'b0;
        idle_reqs();
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        alu_busy   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_alu_side", {alu_start, alu_fun7, alu_fun3, alu_rs1, alu_rs2}, 0);
        chk("reset_rsp_side", {rsp0_valid, rsp1_valid, rsp_res, rsp_zero, rsp_neg, rsp_err}, 0);
        chk("reset_req_ready", {req0_ready, req1_ready}, 0);
        @(posedge clk); #1 reset = 1'b1;

        // 1: port0 ADD 5+7, done one cycle after start
        done_delay = 1;
        drive(0, 7'h00, ALU_ADDSUB, 32'd5, 32'd7);
        q0.push_back(mk(32'd12, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        chk("t1_req_ready_T", {req0_ready, req1_ready}, 2'b10);
        @(posedge clk); #1 idle_reqs();
        @(negedge clk);
        chk("t1_alu_start_T1", alu_start, 1);
        chk("t1_alu_operands", {alu_fun7, alu_fun3, alu_rs1, alu_rs2}, {7'h00, ALU_ADDSUB, 32'd5, 32'd7});
        @(negedge clk);
        chk("t1_start_single_T2", {alu_start, rsp0_valid}, 2'b00);
        @(negedge clk);
        chk("t1_rsp0_valid_T3", {rsp0_valid, rsp1_valid}, 2'b10);
        wait_drain("t1");

        // 2: both ports requesting continuously from reset -> grants 0,1,0,1
        do_reset();
        g_exp[0] = 1'b0; g_exp[1] = 1'b1; g_exp[2] = 1'b0; g_exp[3] = 1'b1;
        drive(0, 7'h00, ALU_ADDSUB, 32'd1, 32'd2);
        drive(1, 7'h20, ALU_ADDSUB, 32'd3, 32'd5);
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clk);
            while (!(req0_ready || req1_ready) && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("t2_grant_seen", req0_ready | req1_ready, 1);
            chk("t2_grant_order", req1_ready, g_exp[k]);
            if (req1_ready) q1.push_back(mk(32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0));
            else            q0.push_back(mk(32'd3, 1'b0, 1'b0, 1'b0));
            @(posedge clk);
        end
        #1 idle_reqs();
        wait_drain("t2");

        // 3: ALU never completes -> timeout after TIMEOUT WAIT cycles
        done_delay = 0;
        issue("t3_timeout", 0, 7'h00, ALU_ADDSUB, 32'd9, 32'd9, mk(32'd0, 1'b1, 1'b0, 1'b1));
        rsp_latency("t3_timeout", 2 + TIMEOUT);
        wait_drain("t3_timeout");
        // done on the last permitted WAIT cycle wins over the timeout
        done_delay = TIMEOUT;
        issue("t3_edge", 1, 7'h20, ALU_ADDSUB, 32'd100, 32'd100, mk(32'd0, 1'b1, 1'b0, 1'b0));
        rsp_latency("t3_edge", 2 + TIMEOUT);
        wait_drain("t3_edge");
        done_delay = 2;
        issue("t3_next", 1, 7'h00, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, mk(32'h0000_F000, 1'b0, 1'b0, 1'b0));
        wait_drain("t3_next");

        // 4: alu_busy stalls ISSUE, then response held by rsp0_ready low
        done_delay = 1;
        alu_busy   = 1'b1;
        rsp0_ready = 1'b0;
        issue("t4", 0, 7'h00, ALU_XOR, 32'h0000_00FF, 32'h0000_000F, mk(32'h0000_00F0, 1'b0, 1'b0, 1'b0));
        repeat (3) begin
            @(negedge clk);
            chk("t4_no_start_while_busy", alu_start, 0);
        end
        @(posedge clk); #1 alu_busy = 1'b0;
        @(negedge clk);
        chk("t4_start_after_busy", alu_start, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_start_single", alu_start, 0);
        @(posedge clk); #1;
        drive(0, 7'h00, ALU_OR, 32'd1, 32'd2);
        q0.push_back(mk(32'd3, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_rsp_held", {rsp0_valid, rsp_res, rsp_zero, rsp_neg, rsp_err}, {1'b1, 32'h0000_00F0, 3'b000});
            chk("t4_no_grant_in_resp", {req0_ready, req1_ready}, 0);
            @(posedge clk); #1;
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        chk("t4_no_grant_on_handshake", {rsp0_valid, req0_ready}, 2'b10);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_grant_after_resp", {rsp0_valid, req0_ready}, 2'b01);
        @(posedge clk); #1 idle_reqs();
        wait_drain("t4");

        // 5: reset during WAIT discards the op; late done ignored; port0 favoured again
        done_delay = 5;
        drive(0, 7'h00, ALU_ADDSUB, 32'd2, 32'd2);
        @(negedge clk);
        chk("t5_accept", req0_ready, 1);
        @(posedge clk); #1 idle_reqs();
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(negedge clk);
        chk("t5_alu_side_cleared", {alu_start, alu_fun7, alu_fun3, alu_rs1, alu_rs2}, 0);
        chk("t5_rsp_side_cleared", {rsp0_valid, rsp1_valid, rsp_res, rsp_zero, rsp_neg, rsp_err}, 0);
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid || alu_start) bad++;
        end
        chk("t5_late_done_ignored", bad, 0);
        @(posedge clk); #1;
        done_delay = 1;
        drive(0, 7'h00, ALU_ADDSUB, 32'd4, 32'd4);
        drive(1, 7'h20, ALU_ADDSUB, 32'd10, 32'd3);
        @(negedge clk);
        chk("t5_port0_first", {req0_ready, req1_ready}, 2'b10);
        q0.push_back(mk(32'd8, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1 req0_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!req1_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_port1_second", req1_ready, 1);
        q1.push_back(mk(32'd7, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1 idle_reqs();
        wait_drain("t5");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
